shift_add_seq: RTL

Time-multiplexed sequencer for one shared shift-add datapath (in0 ± (in1 shifted), with signed shift selecting which operand is scaled). It evaluates a programmable shift-add graph, such as one constant-multiplier adder tree of a mixer layer, over a small register file at one op per cycle. It sits between the activation stream and the downstream ReLU/quantiser stage, and replaces N_OPS unrolled adders with a single one.

---
 rtl/shift_add_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/shift_add_seq.sv
// shift_add_seq: time-multiplexed sequencer driving one shared shift-add
// datapath. A job loads N_IN operands into a small register file. The job then
// runs up to N_OPS programmed ops, one op per cycle. Each op computes
// in0 +/- (in1 shifted), and the sign of the shift selects which operand is
// scaled. Op k writes register N_IN+k. The last op's value is presented on
// out_data.
//
// Optional feature: define SHIFT_ADD_SEQ_SAT_EN to saturate every op result
// to the BW-bit signed range. Without it, results wrap, which is plain
// two's-complement truncation.
module shift_add_seq #(
  parameter int BW      = 16,
  parameter int N_IN    = 4,
  parameter int N_OPS   = 12,
  parameter int SHIFT_W = 5,
  parameter int IDX_W   = 4,
  parameter int OP_W    = 1 + SHIFT_W + 2 * IDX_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prog_we,
  input  logic [$clog2(N_OPS)-1:0]     prog_addr,
  input  logic [OP_W-1:0]              prog_data,
  input  logic [$clog2(N_OPS+1)-1:0]   op_count,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*BW-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BW-1:0]                out_data,
  output logic                         busy
);

  localparam int PA_W  = $clog2(N_OPS);
  localparam int CNT_W = $clog2(N_OPS + 1);
  localparam int N_REG = N_IN + N_OPS;
  // Headroom: the largest shift is 2^(SHIFT_W-1), plus one bit for the add.
  localparam int EW    = BW + (1 << (SHIFT_W - 1)) + 1;

  localparam logic [CNT_W-1:0] N_OPS_C   = CNT_W'(N_OPS);
  localparam logic [PA_W:0]    N_OPS_A   = (PA_W + 1)'(N_OPS);
  localparam logic [IDX_W:0]   N_REG_C   = (IDX_W + 1)'(N_REG);
  localparam logic [IDX_W-1:0] N_IN_IDX  = IDX_W'(N_IN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reduce an extended-precision op result to the BW-bit register width.
  function automatic logic signed [BW-1:0] narrow(input logic signed [EW-1:0] v);
`ifdef SHIFT_ADD_SEQ_SAT_EN
    // The value fits only when every bit above the BW-bit sign bit repeats the sign.
    if (v[EW-1:BW-1] != {(EW - BW + 1){v[EW-1]}})
      return v[EW-1] ? {1'b1, {(BW - 1){1'b0}}} : {1'b0, {(BW - 1){1'b1}}};
    return v[BW-1:0];
`else
    return BW'(v);
`endif
  endfunction

  // Control state
  state_t               state_q, state_d;
  logic [PA_W-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [BW-1:0] result_q, result_d;

  // Data storage. It is not reset: the register file is cleared on every
  // accept, and the program memory persists across resets.
  logic signed [BW-1:0] regs_q [N_REG];
  logic signed [BW-1:0] regs_d [N_REG];
  logic [OP_W-1:0]      prog_q [N_OPS];
  logic [OP_W-1:0]      prog_d [N_OPS];

  // Datapath signals for the op at pc_q
  logic [OP_W-1:0]      op_word;
  logic [IDX_W-1:0]     src0, src1, wr_idx;
  logic [SHIFT_W-1:0]   shift;
  logic                 is_sub;
  logic                 sh_neg, sh_pos;
  logic signed [SHIFT_W:0] shift_ext;
  logic [SHIFT_W:0]     shamt;
  logic signed [BW-1:0] a_val, b_val, wr_val;
  logic signed [EW-1:0] a_ext, b_ext, a_sh, b_sh, sum_ext;
  logic [CNT_W-1:0]     cnt_last;
  logic                 last_op;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = result_q;

  // Decode the current op, fetch operands and evaluate the shared shift-add.
  always_comb begin
    op_word   = prog_q[pc_q];
    src0      = op_word[IDX_W-1:0];
    src1      = op_word[2*IDX_W-1:IDX_W];
    shift     = op_word[2*IDX_W +: SHIFT_W];
    is_sub    = op_word[OP_W-1];
    // Indices past the register file read as zero.
    a_val     = ({1'b0, src0} < N_REG_C) ? regs_q[src0] : '0;
    b_val     = ({1'b0, src1} < N_REG_C) ? regs_q[src1] : '0;
    a_ext     = {{(EW - BW){a_val[BW-1]}}, a_val};
    b_ext     = {{(EW - BW){b_val[BW-1]}}, b_val};
    // Widen the shift by one bit so that negating the most negative value cannot overflow.
    shift_ext = {shift[SHIFT_W-1], shift};
    sh_neg    = shift[SHIFT_W-1];
    sh_pos    = !sh_neg && (shift != '0);
    shamt     = sh_neg ? (-shift_ext) : shift_ext;
    a_sh      = a_ext;
    b_sh      = b_ext;
    if (sh_pos)
      b_sh = b_ext <<< shamt;
    else if (sh_neg)
      a_sh = a_ext <<< shamt;
    sum_ext   = is_sub ? (a_sh - b_sh) : (a_sh + b_sh);
    wr_val    = narrow(sum_ext);
    wr_idx    = N_IN_IDX + IDX_W'(pc_q);
    cnt_last  = cnt_q - CNT_W'(1);
    last_op   = (CNT_W'(pc_q) == cnt_last);
  end

  // Next-state logic for the job FSM, the register file and the result register.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    regs_d   = regs_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N_REG; i++)
            regs_d[i] = (i < N_IN) ? in_data[i*BW +: BW] : '0;
          cnt_d   = (op_count > N_OPS_C) ? N_OPS_C : op_count;
          pc_d    = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          // A zero-op job still spends one cycle here. In that cycle it
          // forwards reg 0, so out_valid rises one cycle after accept.
          result_d = regs_q[0];
          state_d  = S_DONE;
        end else begin
          regs_d[wr_idx] = wr_val;
          result_d       = wr_val;
          if (last_op)
            state_d = S_DONE;
          else
            pc_d = pc_q + PA_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program memory write port. Writes are taken only while no job is in flight.
  always_comb begin
    prog_d = prog_q;
    if (prog_we && !busy && ({1'b0, prog_addr} < N_OPS_A))
      prog_d[prog_addr] = prog_data;
  end

  // Control registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Register file and program memory, with no reset.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    prog_q <= prog_d;
  end

endmodule
